divider_unit: RTL and testbench

- Sequential restoring divider for the multi-cycle MIPS core's DIV/DIVU. It is the inverse counterpart of the Booth multiplier datapath.
- Accepts dividend/divisor on a start pulse and produces one quotient bit per clock.
- Applies a final sign-correction cycle, then returns {remainder, quotient} in HI/LO order with a one-cycle done pulse.
- Sits beside the multiplier in the execute stage; the core control FSM stalls on busy.

---
 rtl/mdu_pkg.sv | 10 +
 rtl/divider_unit_div_step.sv | 18 +
 rtl/divider_unit.sv | 103 ++++++++++
 tb/tb_divider_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: types and constants shared by the multiplier and divider datapaths.
// HI/LO slice indices locate {remainder, quotient} in the double-width result.
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_t;
    localparam int MDU_DATA_WIDTH = 32;
    localparam int LO_LSB = 0;
    localparam int LO_MSB = MDU_DATA_WIDTH - 1;
    localparam int HI_LSB = MDU_DATA_WIDTH;
    localparam int HI_MSB = 2 * MDU_DATA_WIDTH - 1;
endpackage

// File: rtl/divider_unit_div_step.sv
// div_step: one combinational restoring-division step on {P, Q}.
module div_step import mdu_pkg::*; #(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   i_p,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH:0]   o_p,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_trial;
    assign w_shift = {i_p, i_q[DATA_WIDTH-1]};
    // The top bit of the widened difference is the borrow: set means the trial went negative.
    assign w_trial = w_shift - {2'b00, i_d};
    assign o_p = (DATA_WIDTH + 1)'(w_trial[DATA_WIDTH+1] ? w_shift : w_trial);
    assign o_q = {i_q[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH+1]};
endmodule

// File: rtl/divider_unit.sv
// divider_unit: sequential restoring divider for DIV/DIVU, one quotient bit per clock,
// followed by a sign-fix cycle; result is {remainder, quotient}.
module divider_unit import mdu_pkg::*; #(
    parameter int DATA_WIDTH    = MDU_DATA_WIDTH,
    parameter int COUNTER_WIDTH = 6
) (
    input  logic                      RST,
    input  logic                      CLK,
    input  logic                      start,
    input  logic                      sign_en,
    input  logic [DATA_WIDTH-1:0]     Operand1,
    input  logic [DATA_WIDTH-1:0]     Operand2,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero,
    output logic [2*DATA_WIDTH-1:0]   result
);
    mdu_state_t                r_state, w_state_next;
    logic [DATA_WIDTH:0]       r_p, w_p_next;
    logic [DATA_WIDTH-1:0]     r_q, w_q_next;
    logic [DATA_WIDTH-1:0]     r_d;
    logic [DATA_WIDTH-1:0]     r_op1;
    logic [COUNTER_WIDTH-1:0]  r_count;
    logic                      r_quo_neg, r_rem_neg, r_dz;
    logic                      r_div_by_zero, r_done;
    logic [2*DATA_WIDTH-1:0]   r_result;
    logic [DATA_WIDTH-1:0]     w_abs1, w_abs2, w_rem, w_fix_rem, w_fix_quo;
    logic                      w_last;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign w_abs1    = (sign_en & Operand1[DATA_WIDTH-1]) ? -Operand1 : Operand1;
    assign w_abs2    = (sign_en & Operand2[DATA_WIDTH-1]) ? -Operand2 : Operand2;
    assign w_rem     = r_p[DATA_WIDTH-1:0];
    assign w_fix_rem = r_rem_neg ? -w_rem : w_rem;
    assign w_fix_quo = r_quo_neg ? -r_q : r_q;
    assign w_last    = r_count == COUNTER_WIDTH'(DATA_WIDTH - 1);

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_p(r_p),
        .i_q(r_q),
        .i_d(r_d),
        .o_p(w_p_next),
        .o_q(w_q_next)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
                       (r_state == CALC) ? (w_last ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p           <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_op1         <= '0;
            r_count       <= '0;
            r_quo_neg     <= 1'b0;
            r_rem_neg     <= 1'b0;
            r_dz          <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
        end else begin
            r_done <= r_state == FIX;
            case (r_state)
                IDLE: if (start) begin
                    r_p           <= '0;
                    r_q           <= w_abs1;
                    r_d           <= w_abs2;
                    r_op1         <= Operand1;
                    r_count       <= '0;
                    r_quo_neg     <= sign_en & (Operand1[DATA_WIDTH-1] ^ Operand2[DATA_WIDTH-1]);
                    r_rem_neg     <= sign_en & Operand1[DATA_WIDTH-1];
                    r_dz          <= Operand2 == '0;
                    r_div_by_zero <= 1'b0;
                end
                CALC: begin
                    r_p     <= w_p_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 1'b1;
                end
                FIX: begin
                    r_result      <= r_dz ? {r_op1, {DATA_WIDTH{1'b1}}} : {w_fix_rem, w_fix_quo};
                    r_div_by_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = r_state != IDLE;
        done        = r_done;
        div_by_zero = r_div_by_zero;
        result      = r_result;
    end
endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: table vectors, randomized ops against an arithmetic model,
// and hand-written sequences for ignored start, back-to-back start and mid-op reset.
module tb_divider_unit;
    import mdu_pkg::*;
    localparam int W = 32;
    localparam int LAT = 34;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic          sign_en = 1'b0;
    logic [W-1:0]  Operand1 = '0;
    logic [W-1:0]  Operand2 = '0;
    logic          busy, done, div_by_zero;
    logic [2*W-1:0] result;

    int checks = 0;
    int failures = 0;

    divider_unit dut (
        .RST(RST), .CLK(CLK), .start(start), .sign_en(sign_en),
        .Operand1(Operand1), .Operand2(Operand2),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .result(result)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         se;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: native integer division; 64-bit signed math truncates toward zero with dividend-signed remainder.
    function automatic logic [64:0] model(input logic se, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [W-1:0] q, r;
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        if (se) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    task automatic run_op(input logic se, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] res, output logic dz, output int lat, output int bcnt);
        @(negedge CLK);
        sign_en = se; Operand1 = a; Operand2 = b; start = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            @(posedge CLK); #1;
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (busy && done) check("busy_done_overlap", 1, 0);
        end while (!done && lat < 100);
        res = result; dz = div_by_zero;
    endtask

    task automatic check_op(input string tag, input logic se, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r, input logic edz);
        logic [2*W-1:0] res;
        logic dz;
        int lat, bcnt;
        run_op(se, a, b, res, dz, lat, bcnt);
        check({tag, "_quo"}, res[LO_MSB:LO_LSB], q);
        check({tag, "_rem"}, res[HI_MSB:HI_LSB], r);
        check({tag, "_dz"}, dz, edz);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busy"}, bcnt, LAT - 1);
    endtask

    vec_t vecs[11];

    initial begin
        logic [64:0] m;
        logic [2*W-1:0] first_res;
        logic [W-1:0] a, b;
        int lat, seen, unstable;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 1'b0};
        vecs[3]  = '{1'b1, 32'h12345678,   32'h0,          32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,          32'h0,          32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 32'd7,          32'd100,        32'h00000000, 32'h00000007, 1'b0};
        vecs[10] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000, 32'h00000000, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dz", div_by_zero, 0);
        check("reset_result", result, 0);
        @(negedge CLK) RST = 1'b1;

        for (int i = 0; i < 11; i++)
            check_op($sformatf("vec%0d", i), vecs[i].se, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 15);
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            m = model(i[0], a, b);
            check_op($sformatf("rand%0d", i), i[0], a, b, m[W-1:0], m[2*W-1:W], m[2*W]);
        end

        // start pulses while busy must be ignored
        @(negedge CLK);
        sign_en = 1'b0; Operand1 = 32'd1000; Operand2 = 32'd3; start = 1'b1;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            start = (lat == 4 || lat == 19);
            if (start) begin sign_en = 1'b1; Operand1 = 32'd55; Operand2 = 32'd5; end
        end while (!done && lat < 100);
        m = model(1'b0, 32'd1000, 32'd3);
        check("ignore_lat", lat, LAT);
        check("ignore_result", result, m[2*W-1:0]);
        first_res = result;

        // back-to-back start in the done cycle; result must hold until the second done
        sign_en = 1'b1; Operand1 = 32'hFFFFFC18; Operand2 = 32'd3; start = 1'b1;
        lat = 0; unstable = 0;
        do begin
            @(posedge CLK); #1;
            start = 1'b0;
            lat++;
            if (!done && result !== first_res) unstable++;
        end while (!done && lat < 100);
        m = model(1'b1, 32'hFFFFFC18, 32'd3);
        check("b2b_lat", lat, LAT);
        check("b2b_stable", unstable, 0);
        check("b2b_result", result, m[2*W-1:0]);

        // asynchronous reset during CALC aborts the operation
        @(negedge CLK);
        sign_en = 1'b0; Operand1 = 32'd999; Operand2 = 32'd10; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_dz", div_by_zero, 0);
        @(negedge CLK) RST = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done || busy) seen++;
        end
        check("abort_no_done", seen, 0);
        check_op("post_abort", 1'b0, 32'd999, 32'd10, 32'd99, 32'd9, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
